step_sequencer: RTL

Execution controller for the 16-bit RISC core's single-step / run front panel. Consumes the one-shot button pulses produced by the board's debounce stages, generates the slow sampling tick those stages run from, and drives the processor's clock-enable so the core advances exactly one instruction per step press, runs freely, or halts cleanly at an instruction boundary. Also counts retired instructions and guards against a hung core with a watchdog.

---
 rtl/step_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/step_sequencer.sv
// Single-step / run front-panel controller: sequences the core clock-enable, retires-counter,
// watchdog and debounce sampling tick. Optional breakpoint halting enabled by `define STEP_BREAK_EN.
module step_sequencer #(
  parameter int TICK_DIV = 250000,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             step_p,
  input  logic             run_p,
  input  logic             halt_p,
  input  logic             cpu_done,
  input  logic [15:0]      pc,
  input  logic [15:0]      bp_addr,
  input  logic             bp_valid,
  output logic             cpu_en,
  output logic             running,
  output logic             db_tick,
  output logic [CNT_W-1:0] retired,
  output logic             bp_hit,
  output logic             fault,
  output logic [1:0]       state
);

  // state   | meaning
  // HALTED  | core frozen, waiting for run/step press
  // STEP    | core enabled until one instruction retires
  // RUN     | core free-running
  // DRAIN   | halt requested, finishing the in-flight instruction
  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_STEP   = 2'd1,
    S_RUN    = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt, tick_nxt;
  logic [WD_W-1:0]   wd_cnt, wd_nxt;
  logic              retire;
  logic              wd_expired;
  logic              bp_match;
  logic              clr_flags;
  logic              set_fault;
  logic              set_bp;

  assign retire     = cpu_en & cpu_done;
  assign wd_expired = (wd_cnt == WD_LIMIT);
  assign state      = state_q;

`ifdef STEP_BREAK_EN
  assign bp_match = bp_valid && (pc == bp_addr);
`else
  logic unused_bp;
  assign bp_match  = 1'b0;
  assign unused_bp = ^{pc, bp_addr, bp_valid};
`endif

  // Sampling tick for the debounce stages, free-running regardless of the FSM.
  always_comb begin
    tick_nxt = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      db_tick  <= 1'b0;
    end else begin
      tick_cnt <= tick_nxt;
      db_tick  <= (tick_nxt == TICK_LAST);
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_flags = 1'b0;
    set_fault = 1'b0;
    set_bp    = 1'b0;
    case (state_q)
      S_HALTED: begin
        if (!halt_p) begin
          if (run_p) begin
            state_d   = S_RUN;
            clr_flags = 1'b1;
          end else if (step_p) begin
            state_d   = S_STEP;
            clr_flags = 1'b1;
          end
        end
      end
      S_STEP: begin
        if (retire) begin
          state_d = S_HALTED;
        end else if (run_p) begin
          state_d = S_RUN;
        end else if (wd_expired) begin
          state_d   = S_HALTED;
          set_fault = 1'b1;
        end
      end
      S_RUN: begin
        // A breakpoint hit wins over a simultaneous halt so the cause is recorded.
        if (retire && bp_match) begin
          state_d = S_HALTED;
          set_bp  = 1'b1;
        end else if (halt_p) begin
          state_d = retire ? S_HALTED : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (retire) begin
          state_d = S_HALTED;
        end else if (wd_expired) begin
          state_d   = S_HALTED;
          set_fault = 1'b1;
        end
      end
      default: state_d = S_HALTED;
    endcase
  end

  // Watchdog only ages while waiting on a single instruction to finish.
  always_comb begin
    wd_nxt = '0;
    if ((state_d == state_q) && !retire &&
        ((state_q == S_STEP) || (state_q == S_DRAIN))) begin
      wd_nxt = wd_expired ? wd_cnt : wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= S_HALTED;
      cpu_en  <= 1'b0;
      running <= 1'b0;
      wd_cnt  <= '0;
      retired <= '0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      cpu_en  <= (state_d != S_HALTED);
      running <= (state_d == S_RUN) || (state_d == S_DRAIN);
      wd_cnt  <= wd_nxt;
      if (retire) begin
        retired <= retired + 1'b1;
      end
      if (set_fault) begin
        fault <= 1'b1;
      end else if (clr_flags) begin
        fault <= 1'b0;
      end
    end
  end

`ifdef STEP_BREAK_EN
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      bp_hit <= 1'b0;
    end else if (set_bp) begin
      bp_hit <= 1'b1;
    end else if (clr_flags) begin
      bp_hit <= 1'b0;
    end
  end
`else
  assign bp_hit = 1'b0;
`endif

endmodule
